// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
//   Constants and types shared by the pipelined 16x16 multiplier, the product
//   accumulator that consumes its results, and their benches.
//
//   PROD_W        width of a multiplier result
//   MULT_LATENCY  cycles from the operand capture edge to the result-valid cycle
//   tag_t         per-issue bookkeeping carried alongside the multiplier
//                 pipeline: {valid, last}
// -----------------------------------------------------------------------------
package mult_pkg;

  localparam int PROD_W       = 32;
  localparam int MULT_LATENCY = 6;

  typedef struct packed {
    logic valid;  // an operand pair entered the multiplier on this slot
    logic last;   // that pair closes the current frame
  } tag_t;

  // Build a tag from raw issue strobes. A last marker without a valid issue
  // carries no meaning, so it is masked here once for every user.
  function automatic tag_t make_tag(input logic valid, input logic last);
    tag_t t;
    t.valid = valid;
    t.last  = valid & last;
    return t;
  endfunction

endpackage : mult_pkg

// File: rtl/mult_tag_pipe.sv
// -----------------------------------------------------------------------------
// mult_tag_pipe
//   LATENCY-deep shift register of issue tags. It runs in lock-step with the
//   multiplier pipeline, so the tag leaving the last stage describes the
//   product currently on the multiplier's result bus.
//
//   Ports
//     clk        rising-edge clock
//     rst_n      asynchronous active-low clear (drops every tag in flight)
//     tag_in     tag for the operand pair issued this cycle
//     tag_out    tag for the product retiring this cycle
//     any_valid  at least one stage holds a valid tag
// -----------------------------------------------------------------------------
module mult_tag_pipe
  import mult_pkg::*;
#(
  parameter int LATENCY = MULT_LATENCY
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t tag_in,
  output tag_t tag_out,
  output logic any_valid
);

  tag_t [LATENCY-1:0] stage_q;
  tag_t [LATENCY-1:0] stage_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    stage_d    = stage_q;
    stage_d[0] = tag_in;
    for (int i = 1; i < LATENCY; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples its pre-edge inputs regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < LATENCY; i++) begin
      any_valid = any_valid | stage_q[i].valid;
    end
  end

  assign tag_out = stage_q[LATENCY-1];

endmodule : mult_tag_pipe

// File: rtl/product_accumulator.sv
// -----------------------------------------------------------------------------
// product_accumulator
//   Consumer of the pipelined 16x16 multiplier. It tags every issued operand
//   pair, picks each product off the multiplier result bus when its tag
//   retires, and sums products into frames with saturation. Each completed
//   frame (sum, count, saturation flag) is held on a valid/ready output.
//   Issue is throttled so that at most one completed frame is outstanding:
//   once the last pair of a frame is issued, nothing more is accepted until
//   that frame has been taken.
//
//   Ports
//     clk          rising-edge clock
//     rst          asynchronous active-low reset
//     issue_valid  operand pair driven to the multiplier this cycle
//     issue_last   that pair closes the frame (qualified by the issue)
//     issue_ready  upstream may issue; issue = issue_valid & issue_ready
//     product      multiplier result bus
//     out_valid    a completed frame is held
//     out_ready    consumer accepts the held frame
//     out_sum      saturated frame sum
//     out_count    number of products in the frame (saturating)
//     out_sat      the frame sum was clamped at least once
//     busy         a tag is in flight or the accumulator holds a partial frame
//
//   ACC_W must be >= PROD_W.
// -----------------------------------------------------------------------------
module product_accumulator #(
  parameter int LATENCY = mult_pkg::MULT_LATENCY,
  parameter int PROD_W  = mult_pkg::PROD_W,
  parameter int ACC_W   = 40,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               issue_valid,
  input  logic               issue_last,
  output logic               issue_ready,
  input  logic [PROD_W-1:0]  product,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_sum,
  output logic [COUNT_W-1:0] out_count,
  output logic               out_sat,
  output logic               busy
);

  // ---------------------------------------------------------------------------
  // Issue tagging
  // ---------------------------------------------------------------------------
  logic          last_pending_q, last_pending_d;
  logic          issue_fire;
  mult_pkg::tag_t issue_tag;
  mult_pkg::tag_t retire_tag;
  logic          tags_in_flight;

  // issue_ready comes straight off a flop, so out_ready has no combinational
  // path to it; the throttle releases the cycle after the handshake.
  assign issue_ready = ~last_pending_q;
  assign issue_fire  = issue_valid & issue_ready;
  assign issue_tag   = mult_pkg::make_tag(issue_fire, issue_last);

  mult_tag_pipe #(
    .LATENCY (LATENCY)
  ) u_tag_pipe (
    .clk       (clk),
    .rst_n     (rst),
    .tag_in    (issue_tag),
    .tag_out   (retire_tag),
    .any_valid (tags_in_flight)
  );

  // ---------------------------------------------------------------------------
  // Accumulator arithmetic
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               sat_q, sat_d;

  logic [ACC_W:0]     sum_ext;
  logic               sum_ovf;
  logic [ACC_W-1:0]   sum_clamped;
  logic [COUNT_W-1:0] count_inc;
  logic               sat_next;

  // One extra bit catches the carry out; acc never exceeds 2^ACC_W-1 and the
  // product fits in ACC_W bits, so ACC_W+1 bits cannot wrap.
  assign sum_ext     = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, product};
  assign sum_ovf     = sum_ext[ACC_W];
  assign sum_clamped = sum_ovf ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
  assign count_inc   = (&count_q) ? count_q : count_q + COUNT_W'(1);
  assign sat_next    = sat_q | sum_ovf;

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_sum_q, out_sum_d;
  logic [COUNT_W-1:0] out_count_q, out_count_d;
  logic               out_sat_q, out_sat_d;
  logic               out_fire;

  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    acc_d          = acc_q;
    count_d        = count_q;
    sat_d          = sat_q;
    out_valid_d    = out_valid_q;
    out_sum_d      = out_sum_q;
    out_count_d    = out_count_q;
    out_sat_d      = out_sat_q;
    last_pending_d = last_pending_q;

    // The taken frame is cleared so the idle output reads as all zeros.
    if (out_fire) begin
      out_valid_d = 1'b0;
      out_sum_d   = '0;
      out_count_d = '0;
      out_sat_d   = 1'b0;
    end

    // A last retire can only happen while the output register is empty: the
    // throttle keeps the next frame's last from issuing until the handshake,
    // and that last is still LATENCY cycles away from retiring.
    if (retire_tag.valid) begin
      if (retire_tag.last) begin
        out_valid_d = 1'b1;
        out_sum_d   = sum_clamped;
        out_count_d = count_inc;
        out_sat_d   = sat_next;
        acc_d       = '0;
        count_d     = '0;
        sat_d       = 1'b0;
      end else begin
        acc_d       = sum_clamped;
        count_d     = count_inc;
        sat_d       = sat_next;
      end
    end

    // Set after clear: an issue cannot coincide with the handshake while
    // last_pending holds issue_ready low, but the ordering keeps a new last
    // from being lost should that ever change.
    if (out_fire) begin
      last_pending_d = 1'b0;
    end
    if (issue_fire && issue_last) begin
      last_pending_d = 1'b1;
    end
  end

  // NOTE: every control and data flop is cleared by the async reset; there is
  // no memory array here, so nothing is left relying on an unknown power-up.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q          <= '0;
      count_q        <= '0;
      sat_q          <= 1'b0;
      out_valid_q    <= 1'b0;
      out_sum_q      <= '0;
      out_count_q    <= '0;
      out_sat_q      <= 1'b0;
      last_pending_q <= 1'b0;
    end else begin
      acc_q          <= acc_d;
      count_q        <= count_d;
      sat_q          <= sat_d;
      out_valid_q    <= out_valid_d;
      out_sum_q      <= out_sum_d;
      out_count_q    <= out_count_d;
      out_sat_q      <= out_sat_d;
      last_pending_q <= last_pending_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_sat   = out_sat_q;

  // A partial frame is recognised by a non-zero product count; the count only
  // returns to zero when the frame closes or on reset.
  assign busy = tags_in_flight | (count_q != '0);

endmodule : product_accumulator

// File: tb/tb_product_accumulator.sv
// -----------------------------------------------------------------------------
// tb_product_accumulator
//   Drives two accumulators (ACC_W=40 and ACC_W=32) from one operand stream.
//   A behavioural multiplier delay line presents each a*b on the product bus
//   LATENCY cycles after its issue and a junk value otherwise. Hand-computed
//   frame results are queued as frames are issued; monitors pop and compare
//   whenever an accumulator presents a frame.
// -----------------------------------------------------------------------------
module tb_product_accumulator;

  localparam int LAT = 6;
  localparam logic [31:0] JUNK = 32'h0BAD_F00D;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        issue_valid = 1'b0;
  logic        issue_last = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] a_r = '0;
  logic [15:0] b_r = '0;
  logic [31:0] product;

  logic        ir40, ov40, sat40, busy40;
  logic [39:0] sum40;
  logic [15:0] cnt40;
  logic        ir32, ov32, sat32, busy32;
  logic [31:0] sum32;
  logic [15:0] cnt32;

  always #5 clk = ~clk;

  product_accumulator #(.LATENCY(LAT), .PROD_W(32), .ACC_W(40), .COUNT_W(16)) dut40 (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_last(issue_last),
    .issue_ready(ir40), .product(product), .out_valid(ov40), .out_ready(out_ready),
    .out_sum(sum40), .out_count(cnt40), .out_sat(sat40), .busy(busy40));

  product_accumulator #(.LATENCY(LAT), .PROD_W(32), .ACC_W(32), .COUNT_W(16)) dut32 (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_last(issue_last),
    .issue_ready(ir32), .product(product), .out_valid(ov32), .out_ready(out_ready),
    .out_sum(sum32), .out_count(cnt32), .out_sat(sat32), .busy(busy32));

  // ---------------------------------------------------------------------------
  // Check bookkeeping
  // ---------------------------------------------------------------------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s", name);
  endtask

  // ---------------------------------------------------------------------------
  // Multiplier model and cycle counter
  // ---------------------------------------------------------------------------
  logic [31:0] pipe [LAT] = '{default: JUNK};
  int cyc = 0;
  int last_issue_cyc = -100;
  int last_fire_cyc = -100;
  logic fire_now;

  assign fire_now = issue_valid & ir40;
  assign product  = pipe[LAT-1];

  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= fire_now ? ({16'b0, a_r} * {16'b0, b_r}) : JUNK;
    if (fire_now) begin
      last_fire_cyc <= cyc;
      if (issue_last) last_issue_cyc <= cyc;
    end
    cyc <= cyc + 1;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [39:0] sum40;
    logic [31:0] sum32;
    logic [15:0] count;
    logic        sat40;
    logic        sat32;
  } exp_t;

  exp_t q40[$];
  exp_t q32[$];

  task automatic push_exp(input logic [39:0] s40, input logic [31:0] s32,
                          input logic [15:0] c, input logic st40, input logic st32);
    exp_t e;
    e.sum40 = s40; e.sum32 = s32; e.count = c; e.sat40 = st40; e.sat32 = st32;
    q40.push_back(e);
    q32.push_back(e);
  endtask

  // Each frame is compared once when it appears; while it is held under
  // backpressure its sum must not move.
  logic        popped40 = 1'b0;
  logic [39:0] held40 = '0;
  always @(negedge clk) begin
    if (!rst) begin
      popped40 = 1'b0;
    end else if (ov40) begin
      if (!popped40) begin
        if (q40.size() == 0) begin
          fail_now("acc40 unexpected frame");
        end else begin
          exp_t e;
          e = q40.pop_front();
          check("acc40 sum",   64'(sum40), 64'(e.sum40));
          check("acc40 count", 64'(cnt40), 64'(e.count));
          check("acc40 sat",   64'(sat40), 64'(e.sat40));
          check("acc40 valid cycle", 64'(cyc), 64'(last_issue_cyc + LAT + 1));
        end
        held40   = sum40;
        popped40 = 1'b1;
      end else begin
        check("acc40 held sum", 64'(sum40), 64'(held40));
      end
      if (out_ready) popped40 = 1'b0;
    end
  end

  logic popped32 = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      popped32 = 1'b0;
    end else if (ov32) begin
      if (!popped32) begin
        if (q32.size() == 0) begin
          fail_now("acc32 unexpected frame");
        end else begin
          exp_t e;
          e = q32.pop_front();
          check("acc32 sum",   64'(sum32), 64'(e.sum32));
          check("acc32 count", 64'(cnt32), 64'(e.count));
          check("acc32 sat",   64'(sat32), 64'(e.sat32));
        end
        popped32 = 1'b1;
      end
      if (out_ready) popped32 = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  // Present one operand pair, waiting (bounded) for issue_ready.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic last);
    int n = 0;
    @(negedge clk);
    while (!ir40 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ir40) begin
      fail_now("issue_ready timeout");
    end else begin
      a_r = a; b_r = b; issue_last = last; issue_valid = 1'b1;
      @(posedge clk);
      #1;
      issue_valid = 1'b0;
      issue_last  = 1'b0;
    end
  endtask

  // Wait until every queued frame has been seen and both accumulators idle.
  task automatic wait_idle();
    int n = 0;
    while ((q40.size() != 0 || q32.size() != 0 || ov40 || ov32 || busy40 || busy32)
           && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 300) fail_now("wait_idle timeout");
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int t0;
    int n;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset issue_ready", 64'(ir40), 64'd1);
    check("reset out_valid",   64'(ov40), 64'd0);
    check("reset out_sum",     64'(sum40), 64'd0);
    check("reset out_count",   64'(cnt40), 64'd0);
    check("reset out_sat",     64'(sat40), 64'd0);
    check("reset busy",        64'(busy40), 64'd0);
    check("reset acc32 valid", 64'(ov32), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Two-product frame: 3*7 + 50*200
    push_exp(40'd10021, 32'd10021, 16'd2, 1'b0, 1'b0);
    issue(16'd3, 16'd7, 1'b0);
    check("busy after issue", 64'(busy40), 64'd1);
    issue(16'd50, 16'd200, 1'b1);
    check("issue_ready after last", 64'(ir40), 64'd0);
    wait_idle();

    // Single-product frame at the operand limit
    push_exp(40'd4294836225, 32'd4294836225, 16'd1, 1'b0, 1'b0);
    issue(16'hFFFF, 16'hFFFF, 1'b1);
    wait_idle();

    // Saturation: clamps in the 32-bit accumulator, not in the 40-bit one
    push_exp(40'd12884508675, 32'hFFFF_FFFF, 16'd3, 1'b0, 1'b1);
    issue(16'hFFFF, 16'hFFFF, 1'b0);
    issue(16'hFFFF, 16'hFFFF, 1'b0);
    issue(16'hFFFF, 16'hFFFF, 1'b1);
    wait_idle();
    push_exp(40'd1, 32'd1, 16'd1, 1'b0, 1'b0);
    issue(16'd1, 16'd1, 1'b1);
    wait_idle();

    // Back-to-back frames; the second frame issues LATENCY+2 after the last
    push_exp(40'd4194304, 32'd4194304, 16'd1, 1'b0, 1'b0);
    issue(16'd1024, 16'd4096, 1'b1);
    t0 = last_issue_cyc;
    push_exp(40'd33354, 32'd33354, 16'd2, 1'b0, 1'b0);
    issue(16'd42, 16'd17, 1'b0);
    check("frame-to-frame gap", 64'(last_fire_cyc - t0), 64'(LAT + 2));
    issue(16'd128, 16'd255, 1'b1);
    wait_idle();

    // Backpressure: frame held for 20 cycles, stray issue pulses ignored
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    push_exp(40'd10000, 32'd10000, 16'd1, 1'b0, 1'b0);
    issue(16'd100, 16'd100, 1'b1);
    n = 0;
    while (!ov40 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!ov40) fail_now("backpressure frame timeout");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i % 3 == 0) begin
        a_r = 16'd9; b_r = 16'd9; issue_valid = 1'b1; issue_last = 1'b1;
      end
      if (i % 5 == 0) begin
        check("held issue_ready", 64'(ir40), 64'd0);
        check("held out_valid",   64'(ov40), 64'd1);
      end
      @(posedge clk);
      #1;
      issue_valid = 1'b0;
      issue_last  = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("issue_ready after release", 64'(ir40), 64'd1);
    check("out_valid after release",   64'(ov40), 64'd0);
    repeat (LAT + 3) @(posedge clk);
    #1;
    check("no stray frame busy", 64'(busy40), 64'd0);
    wait_idle();

    // Reset mid-frame: partial products must not leak into the next frame
    issue(16'd5, 16'd6, 1'b0);
    issue(16'd7, 16'd8, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid-reset busy",        64'(busy40), 64'd0);
    check("mid-reset issue_ready", 64'(ir40), 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    push_exp(40'd670592745, 32'd670592745, 16'd1, 1'b0, 1'b0);
    issue(16'd12345, 16'd54321, 1'b1);
    wait_idle();

    repeat (3) @(posedge clk);
    #1;
    check("final issue_ready", 64'(ir40), 64'd1);
    check("final busy",        64'(busy40), 64'd0);
    if (q40.size() != 0 || q32.size() != 0) fail_now("frames left in scoreboard");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_product_accumulator

// File: doc/product_accumulator.md
# product_accumulator

Downstream consumer of the pipelined `wallace_multiplier_16bit`. It tracks which operand pairs were issued to the multiplier, captures each 32-bit product when it leaves the multiplier pipeline, and accumulates products into frame sums. It presents each completed frame's sum, product count and saturation flag on a valid/ready output. It also throttles operand issue so that at most one completed frame is ever outstanding.

## Interface
Parameters:
- `LATENCY`, 6: multiplier latency in cycles, from operand capture edge to the result-valid cycle.
- `PROD_W`, 32: product width.
- `ACC_W`, 40: accumulator and `out_sum` width; must be ≥ `PROD_W`.
- `COUNT_W`, 16: product-count width.

Ports (the reset is one clock, asynchronous, active-low):
- `clk`  in  1  sole clock; all state on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `issue_valid`  in  1  operand pair driven to the multiplier this cycle.
- `issue_last`  in  1  marks the final pair of a frame; qualified by issue.
- `issue_ready`  out  1  upstream may issue; issue = `issue_valid & issue_ready`.
- `product`  in  PROD_W  multiplier `result`.
- `out_valid`  out  1  frame result held.
- `out_ready`  in  1  consumer accepts.
- `out_sum`  out  ACC_W  saturated sum of frame products.
- `out_count`  out  COUNT_W  number of products in the frame.
- `out_sat`  out  1  frame sum clamped at least once.
- `busy`  out  1  any tag in flight, or accumulator non-empty.

## Operation
- **Tag pipe.** Tag pipe of `LATENCY` stages carries `{valid,last}`. An issue in cycle t produces a retire in cycle t+`LATENCY`. On retire, `product` is sampled at the end of that cycle.
- **Retire of a non-last product.**
  - acc ← acc + product, evaluated in ACC_W+1 bits. If the result is > 2^ACC_W−1, acc ← all-ones and the frame sat flag is set.
  - count ← count+1, saturating at all-ones.
- **Retire with last.** The same arithmetic is folded in. The final sum, count and sat are loaded into the output register and `out_valid` is set. acc, count and sat clear to 0 in the same edge.
- **Output.** The output register holds stable while `out_valid & !out_ready`. It is cleared on the handshake edge.
- **Issue throttle.** `issue_ready` = !`last_pending`.
  - `last_pending` sets on an issue with `issue_last`.
  - `last_pending` clears on the output handshake edge.
  - Consequences: nothing issued after a last can retire before the frame is taken, and the output register can never be overwritten.
- **Ignored inputs.** `issue_valid` with `issue_ready` low is ignored (no tag is inserted). `issue_last` without `issue_valid` is ignored.
- **Simultaneous events.** A handshake and an issue in the same cycle are legal: `issue_ready` is re-asserted in the cycle after the handshake.
- **Reset.** Async `rst` low mid-operation clears the tag pipe, acc, count, sat, the output register and `last_pending` immediately. In-flight products are discarded.

## Timing
- Reset values: `issue_ready`=1, `out_valid`=0, `out_sum`=0, `out_count`=0, `out_sat`=0, `busy`=0.
- Latency from a last issue in cycle t:
  - `out_valid` rises in cycle t+`LATENCY`+1 (registered after retire).
  - Minimum frame-to-frame issue gap: `LATENCY`+2 cycles when `out_ready` is held high.
- Throughput within a frame: one product per cycle.
- No combinational path from `out_ready` to `issue_ready`; `issue_ready` is a register output.

## Structure
- Shared package `mult_pkg`:
  - `PROD_W` and `MULT_LATENCY` (6) constants, shared with the multiplier and benches.
  - Tag typedef `{valid,last}`.
- Sub-module `mult_tag_pipe`: parameterised `LATENCY`-deep shift register of tags with async active-low clear.
- The accumulator, output register and throttle live in `product_accumulator`.

## Test plan
- **Two-product frame.** Issue 3×7, then 50×200 with last, `out_ready`=1 → `out_sum`=10021, `out_count`=2, `out_sat`=0. `out_valid` is high for exactly one cycle, in the expected cycle.
- **Single-product frame.** Issue 65535×65535 with last → `out_sum`=4294836225, `out_count`=1.
- **Saturation.** With `ACC_W`=32, issue 65535×65535 three times, last on the third → `out_sum`=0xFFFFFFFF, `out_sat`=1. The next frame, 1×1 with last → sum 1, sat 0.
- **Backpressure.** Hold `out_ready`=0 for 20 cycles after a frame completes → `out_sum` is stable and `issue_ready`=0 throughout. Upstream `issue_valid` pulses in that window are ignored. Release `out_ready` → `issue_ready`=1 the next cycle.
- **Back-to-back frames.** Frames {1024×4096} and {42×17, 128×255} with `out_ready`=1 → sums 4194304, then 33354; counts 1, then 2.
- **Reset mid-frame.** Issue two non-last products, assert `rst`=0 for 2 cycles, release, then issue 12345×54321 with last → `out_sum`=670592745, `out_count`=1, with no stale product included.
